// File: rtl/can_frame_format_decoder_pkg.sv
// Shared types and field lengths for the CAN frame-format decoder and its
// DLC-to-length helper.
package can_fmt_pkg;

  typedef enum logic [1:0] {
    FT_CLASSIC_DATA   = 2'b00,
    FT_CLASSIC_REMOTE = 2'b01,
    FT_FD_DATA        = 2'b10,
    FT_NONE           = 2'b11
  } frame_type_t;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_BASE_ID = 4'd1,
    ST_B12     = 4'd2,
    ST_IDE     = 4'd3,
    ST_EXT_ID  = 4'd4,
    ST_RTR_X   = 4'd5,
    ST_FDF     = 4'd6,
    ST_R0      = 4'd7,
    ST_RES     = 4'd8,
    ST_BRS     = 4'd9,
    ST_ESI     = 4'd10,
    ST_DLC     = 4'd11
  } fmt_state_t;

  localparam int BASE_ID_LEN = 11;
  localparam int EXT_ID_LEN  = 18;
  localparam int DLC_LEN     = 4;
  localparam int ID_W        = 29;
  localparam int CNT_W       = 5;

  // Counter value seen while sampling the last bit of a field of 'len' bits.
  function automatic logic [CNT_W-1:0] last_cnt(input int len);
    return CNT_W'(len - 1);
  endfunction

endpackage

// File: rtl/can_frame_format_decoder_dlc_len.sv
// can_dlc_len: combinational DLC + frame type -> payload byte count.
// Shared with the TX path so both directions agree on the FD length table.
module can_dlc_len
  import can_fmt_pkg::*;
#(
  parameter int LEN_W = 7
) (
  input  logic [3:0]       dlc,
  input  frame_type_t      frame_type,
  output logic [LEN_W-1:0] data_len
);

  logic [6:0] len_s;

  // Classic data saturates at 8 bytes; FD uses the extended table; remote and none carry nothing.
  always_comb begin
    len_s = 7'd0;
    case (frame_type)
      FT_CLASSIC_DATA: begin
        if (dlc > 4'd8) begin
          len_s = 7'd8;
        end else begin
          len_s = {3'd0, dlc};
        end
      end
      FT_FD_DATA: begin
        case (dlc)
          4'd9:    len_s = 7'd12;
          4'd10:   len_s = 7'd16;
          4'd11:   len_s = 7'd20;
          4'd12:   len_s = 7'd24;
          4'd13:   len_s = 7'd32;
          4'd14:   len_s = 7'd48;
          4'd15:   len_s = 7'd64;
          default: len_s = {3'd0, dlc};
        endcase
      end
      default: len_s = 7'd0;
    endcase
    data_len = LEN_W'(len_s);
  end

endmodule

// File: rtl/can_frame_format_decoder.sv
// can_frame_format_decoder: walks destuffed arbitration/control bits on
// sample-point strobes and reports frame type, ID, IDE, BRS, ESI, DLC and
// payload length. Optional macro CAN_FMT_PROTOCOL_EXC_EN adds proto_exc,
// which flags a recessive FD reserved bit and aborts the decode.
module can_frame_format_decoder
  import can_fmt_pkg::*;
#(
  parameter int FD_ENABLE = 1,
  parameter int LEN_W     = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sp_valid,
  input  logic             rx_bit,
  input  logic             sof,
  input  logic             abort,
  output logic             busy,
  output logic             fmt_valid,
  output logic [1:0]       frame_type,
  output logic             ide,
  output logic [28:0]      id,
  output logic             brs,
  output logic             esi,
  output logic [3:0]       dlc,
  output logic [LEN_W-1:0] data_len
`ifdef CAN_FMT_PROTOCOL_EXC_EN
  ,
  output logic             proto_exc
`endif
);

  fmt_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ID_W-1:0]   id_acc_q, id_acc_d;
  logic              rtr_q, rtr_d, ide_acc_q, ide_acc_d, fd_q, fd_d;
  logic              brs_acc_q, brs_acc_d, esi_acc_q, esi_acc_d;
  logic [2:0]        dlc_acc_q, dlc_acc_d;

  logic              busy_q, busy_d, fmt_valid_q, fmt_valid_d;
  frame_type_t       frame_type_q, frame_type_d;
  logic              ide_q, ide_d, brs_q, brs_d, esi_q, esi_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [3:0]        dlc_q, dlc_d;
  logic [LEN_W-1:0]  data_len_q, data_len_d;
  logic              proto_exc_q, proto_exc_d;

  logic [3:0]        dlc_full_s;
  frame_type_t       ftype_s;
  logic [LEN_W-1:0]  data_len_s;
  logic              exc_s, kill_s;

  assign dlc_full_s = {dlc_acc_q, rx_bit};
  assign ftype_s    = fd_q ? FT_FD_DATA : (rtr_q ? FT_CLASSIC_REMOTE : FT_CLASSIC_DATA);

  can_dlc_len #(.LEN_W(LEN_W)) u_dlc_len (
    .dlc        (dlc_full_s),
    .frame_type (ftype_s),
    .data_len   (data_len_s)
  );

`ifdef CAN_FMT_PROTOCOL_EXC_EN
  assign exc_s = sp_valid & ~sof & rx_bit & (state_q == ST_RES);
`else
  assign exc_s = 1'b0;
`endif
  assign kill_s = abort | exc_s;

  // Next-state, field accumulation and completion/abort output update.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    id_acc_d     = id_acc_q;
    rtr_d        = rtr_q;
    ide_acc_d    = ide_acc_q;
    fd_d         = fd_q;
    brs_acc_d    = brs_acc_q;
    esi_acc_d    = esi_acc_q;
    dlc_acc_d    = dlc_acc_q;
    fmt_valid_d  = 1'b0;
    frame_type_d = frame_type_q;
    ide_d        = ide_q;
    id_d         = id_q;
    brs_d        = brs_q;
    esi_d        = esi_q;
    dlc_d        = dlc_q;
    data_len_d   = data_len_q;
    proto_exc_d  = exc_s & ~abort;

    if (kill_s) begin
      state_d      = ST_IDLE;
      frame_type_d = FT_NONE;
      ide_d        = 1'b0;
      id_d         = '0;
      brs_d        = 1'b0;
      esi_d        = 1'b0;
      dlc_d        = 4'd0;
      data_len_d   = '0;
    end else if (sp_valid && sof) begin
      // SOF restarts from scratch, discarding any partial frame.
      state_d   = ST_BASE_ID;
      cnt_d     = 5'd0;
      id_acc_d  = '0;
      rtr_d     = 1'b0;
      ide_acc_d = 1'b0;
      fd_d      = 1'b0;
      brs_acc_d = 1'b0;
      esi_acc_d = 1'b0;
      dlc_acc_d = 3'd0;
    end else if (sp_valid) begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_BASE_ID: begin
          id_acc_d = {id_acc_q[ID_W-2:0], rx_bit};
          cnt_d    = cnt_q + 5'd1;
          if (cnt_q == last_cnt(BASE_ID_LEN)) begin
            state_d = ST_B12;
          end else begin
            state_d = ST_BASE_ID;
          end
        end
        ST_B12: begin
          rtr_d   = rx_bit;
          state_d = ST_IDE;
        end
        ST_IDE: begin
          ide_acc_d = rx_bit;
          cnt_d     = 5'd0;
          if (rx_bit) begin
            state_d = ST_EXT_ID;
          end else begin
            state_d = ST_FDF;
          end
        end
        ST_EXT_ID: begin
          id_acc_d = {id_acc_q[ID_W-2:0], rx_bit};
          cnt_d    = cnt_q + 5'd1;
          if (cnt_q == last_cnt(EXT_ID_LEN)) begin
            state_d = ST_RTR_X;
          end else begin
            state_d = ST_EXT_ID;
          end
        end
        ST_RTR_X: begin
          rtr_d   = rx_bit;
          state_d = ST_FDF;
        end
        ST_FDF: begin
          cnt_d = 5'd0;
          if ((FD_ENABLE != 0) && rx_bit) begin
            fd_d    = 1'b1;
            state_d = ST_RES;
          end else if (ide_acc_q) begin
            fd_d    = 1'b0;
            state_d = ST_R0;
          end else begin
            fd_d    = 1'b0;
            state_d = ST_DLC;
          end
        end
        ST_R0: begin
          cnt_d   = 5'd0;
          state_d = ST_DLC;
        end
        ST_RES: state_d = ST_BRS;
        ST_BRS: begin
          brs_acc_d = rx_bit;
          state_d   = ST_ESI;
        end
        ST_ESI: begin
          esi_acc_d = rx_bit;
          cnt_d     = 5'd0;
          state_d   = ST_DLC;
        end
        ST_DLC: begin
          dlc_acc_d = {dlc_acc_q[1:0], rx_bit};
          cnt_d     = cnt_q + 5'd1;
          if (cnt_q == last_cnt(DLC_LEN)) begin
            state_d      = ST_IDLE;
            fmt_valid_d  = 1'b1;
            frame_type_d = ftype_s;
            ide_d        = ide_acc_q;
            id_d         = ide_acc_q ? id_acc_q : {18'd0, id_acc_q[10:0]};
            brs_d        = fd_q & brs_acc_q;
            esi_d        = fd_q & esi_acc_q;
            dlc_d        = dlc_full_s;
            data_len_d   = data_len_s;
          end else begin
            state_d = ST_DLC;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State, accumulators and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 5'd0;
      id_acc_q     <= '0;
      rtr_q        <= 1'b0;
      ide_acc_q    <= 1'b0;
      fd_q         <= 1'b0;
      brs_acc_q    <= 1'b0;
      esi_acc_q    <= 1'b0;
      dlc_acc_q    <= 3'd0;
      busy_q       <= 1'b0;
      fmt_valid_q  <= 1'b0;
      frame_type_q <= FT_NONE;
      ide_q        <= 1'b0;
      id_q         <= '0;
      brs_q        <= 1'b0;
      esi_q        <= 1'b0;
      dlc_q        <= 4'd0;
      data_len_q   <= '0;
      proto_exc_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      id_acc_q     <= id_acc_d;
      rtr_q        <= rtr_d;
      ide_acc_q    <= ide_acc_d;
      fd_q         <= fd_d;
      brs_acc_q    <= brs_acc_d;
      esi_acc_q    <= esi_acc_d;
      dlc_acc_q    <= dlc_acc_d;
      busy_q       <= busy_d;
      fmt_valid_q  <= fmt_valid_d;
      frame_type_q <= frame_type_d;
      ide_q        <= ide_d;
      id_q         <= id_d;
      brs_q        <= brs_d;
      esi_q        <= esi_d;
      dlc_q        <= dlc_d;
      data_len_q   <= data_len_d;
      proto_exc_q  <= proto_exc_d;
    end
  end

  assign busy       = busy_q;
  assign fmt_valid  = fmt_valid_q;
  assign frame_type = frame_type_q;
  assign ide        = ide_q;
  assign id         = id_q;
  assign brs        = brs_q;
  assign esi        = esi_q;
  assign dlc        = dlc_q;
  assign data_len   = data_len_q;
`ifdef CAN_FMT_PROTOCOL_EXC_EN
  assign proto_exc  = proto_exc_q;
`else
  logic unused_exc_s;
  assign unused_exc_s = proto_exc_q;
`endif

endmodule

// File: tb/tb_can_frame_format_decoder.sv
// Scoreboard bench for can_frame_format_decoder: one FD-enabled and one
// classic-only instance, each with its own stimulus lines and expect queue.
module tb_can_frame_format_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [1:0] sp_v, rxb, sofv, abv;

  logic        busy1, fv1, ide1, brs1, esi1, exc1;
  logic [1:0]  ft1;
  logic [28:0] id1;
  logic [3:0]  dlc1;
  logic [6:0]  len1;
  logic        busy0, fv0, ide0, brs0, esi0, exc0;
  logic [1:0]  ft0;
  logic [28:0] id0;
  logic [3:0]  dlc0;
  logic [6:0]  len0;

  can_frame_format_decoder #(.FD_ENABLE(1), .LEN_W(7)) u_fd (
    .clk(clk), .reset(reset), .sp_valid(sp_v[1]), .rx_bit(rxb[1]), .sof(sofv[1]),
    .abort(abv[1]), .busy(busy1), .fmt_valid(fv1), .frame_type(ft1), .ide(ide1),
    .id(id1), .brs(brs1), .esi(esi1), .dlc(dlc1), .data_len(len1)
`ifdef CAN_FMT_PROTOCOL_EXC_EN
    , .proto_exc(exc1)
`endif
  );

  can_frame_format_decoder #(.FD_ENABLE(0), .LEN_W(7)) u_cl (
    .clk(clk), .reset(reset), .sp_valid(sp_v[0]), .rx_bit(rxb[0]), .sof(sofv[0]),
    .abort(abv[0]), .busy(busy0), .fmt_valid(fv0), .frame_type(ft0), .ide(ide0),
    .id(id0), .brs(brs0), .esi(esi0), .dlc(dlc0), .data_len(len0)
`ifdef CAN_FMT_PROTOCOL_EXC_EN
    , .proto_exc(exc0)
`endif
  );

`ifndef CAN_FMT_PROTOCOL_EXC_EN
  assign exc1 = 1'b0;
  assign exc0 = 1'b0;
`endif

  typedef struct {
    logic [1:0]  ft;
    logic        ide;
    logic [28:0] id;
    logic        brs;
    logic        esi;
    logic [3:0]  dlc;
    logic [6:0]  len;
  } exp_t;

  exp_t q1[$];
  exp_t q0[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exc_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] exp_len(input logic [1:0] ft, input logic [3:0] d);
    if (ft == 2'b01) return 7'd0;
    if (ft == 2'b00) return (d > 4'd8) ? 7'd8 : {3'd0, d};
    case (d)
      4'd9:    return 7'd12;
      4'd10:   return 7'd16;
      4'd11:   return 7'd20;
      4'd12:   return 7'd24;
      4'd13:   return 7'd32;
      4'd14:   return 7'd48;
      4'd15:   return 7'd64;
      default: return {3'd0, d};
    endcase
  endfunction

  // FD instance: every fmt_valid pulse must match the oldest expectation.
  always @(negedge clk) begin : mon1
    exp_t e;
    if (!reset && fv1) begin
      if (q1.size() == 0) begin
        chk("fd_unexpected_fmt_valid", 64'd1, 64'd0);
      end else begin
        e = q1.pop_front();
        chk("fd_frame_type", ft1, e.ft);
        chk("fd_ide", ide1, e.ide);
        chk("fd_id", id1, e.id);
        chk("fd_brs", brs1, e.brs);
        chk("fd_esi", esi1, e.esi);
        chk("fd_dlc", dlc1, e.dlc);
        chk("fd_data_len", len1, e.len);
      end
    end
    if (!reset && exc1) exc_cnt++;
  end

  // Classic-only instance scoreboard.
  always @(negedge clk) begin : mon0
    exp_t e;
    if (!reset && fv0) begin
      if (q0.size() == 0) begin
        chk("cl_unexpected_fmt_valid", 64'd1, 64'd0);
      end else begin
        e = q0.pop_front();
        chk("cl_frame_type", ft0, e.ft);
        chk("cl_ide", ide0, e.ide);
        chk("cl_id", id0, e.id);
        chk("cl_brs", brs0, e.brs);
        chk("cl_esi", esi0, e.esi);
        chk("cl_dlc", dlc0, e.dlc);
        chk("cl_data_len", len0, e.len);
      end
    end
  end

  // One sample point followed by an idle cycle carrying a junk rx_bit.
  task automatic sp(input int sel, input bit b, input bit s, input bit a);
    @(negedge clk);
    sp_v[sel] = 1'b1; rxb[sel] = b; sofv[sel] = s; abv[sel] = a;
    @(negedge clk);
    sp_v[sel] = 1'b0; sofv[sel] = 1'b0; abv[sel] = 1'b0; rxb[sel] = 1'($urandom);
  endtask

  // Serialise a frame; stops after bit cut_at (asserting abort on it if cut_abort).
  task automatic send_frame(input int sel, input bit f_ide, input logic [28:0] f_id,
                            input bit rtr, input bit fdf, input bit res, input bit f_brs,
                            input bit f_esi, input logic [3:0] f_dlc, input int cut_at,
                            input bit cut_abort, input bit expect_out);
    bit          bits[$];
    logic [10:0] base;
    bit          fdpath;
    exp_t        e;
    fdpath = fdf && (sel == 1);
    base   = f_ide ? f_id[28:18] : f_id[10:0];
    bits.push_back(1'b0);
    for (int i = 10; i >= 0; i--) bits.push_back(base[i]);
    bits.push_back(f_ide ? 1'b1 : rtr);
    bits.push_back(f_ide);
    if (f_ide) begin
      for (int i = 17; i >= 0; i--) bits.push_back(f_id[i]);
      bits.push_back(rtr);
    end
    bits.push_back(fdf);
    if (fdpath) begin
      bits.push_back(res); bits.push_back(f_brs); bits.push_back(f_esi);
    end else if (f_ide) begin
      bits.push_back(1'b0);
    end
    for (int i = 3; i >= 0; i--) bits.push_back(f_dlc[i]);
    if (expect_out) begin
      e.ft  = fdpath ? 2'b10 : (rtr ? 2'b01 : 2'b00);
      e.ide = f_ide;
      e.id  = f_ide ? f_id : {18'd0, f_id[10:0]};
      e.brs = fdpath & f_brs;
      e.esi = fdpath & f_esi;
      e.dlc = f_dlc;
      e.len = exp_len(e.ft, f_dlc);
      if (sel == 1) q1.push_back(e);
      else q0.push_back(e);
    end
    for (int k = 0; k < bits.size(); k++) begin
      sp(sel, bits[k], k == 0, cut_abort && (k == cut_at));
      if (k == cut_at) break;
    end
  endtask

  initial begin
    reset = 1'b1; sp_v = 2'b00; rxb = 2'b00; sofv = 2'b00; abv = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy1, 1'b0);
    chk("rst_fmt_valid", fv1, 1'b0);
    chk("rst_frame_type", ft1, 2'b11);
    chk("rst_id", id1, 29'd0);
    chk("rst_dlc", dlc1, 4'd0);
    chk("rst_data_len", len1, 7'd0);
    chk("rst_flags", {ide1, brs1, esi1, exc1}, 4'b0000);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    send_frame(1, 0, 29'h123, 0, 0, 0, 0, 0, 4'hA, -1, 0, 1);
    repeat (4) @(negedge clk);
    chk("hold_id", id1, 29'h123);
    chk("hold_busy", busy1, 1'b0);
    send_frame(1, 0, 29'h7FF, 1, 0, 0, 0, 0, 4'h3, -1, 0, 1);
    send_frame(1, 1, 29'h12345678, 0, 1, 0, 1, 0, 4'hD, -1, 0, 1);
    send_frame(1, 0, 29'h2A5, 1, 1, 0, 0, 1, 4'h9, -1, 0, 1);
    send_frame(1, 1, 29'h1ABCDEF0, 0, 0, 0, 0, 0, 4'hF, -1, 0, 1);
    send_frame(1, 1, 29'h00000001, 1, 0, 0, 0, 0, 4'h2, -1, 0, 1);
    send_frame(1, 1, 29'h1FFFFFFF, 0, 1, 0, 0, 1, 4'hF, -1, 0, 1);
    send_frame(0, 0, 29'h555, 0, 1, 0, 0, 0, 4'h5, -1, 0, 1);
    send_frame(0, 1, 29'h0F0F0F0F, 0, 1, 0, 0, 0, 4'h7, -1, 0, 1);

    // abort on the 10th extended-ID bit (bit index 23 counting SOF as 0)
    send_frame(1, 1, 29'h0ABCDE12, 0, 1, 0, 1, 1, 4'hC, 23, 1, 0);
    chk("abort_busy", busy1, 1'b0);
    chk("abort_frame_type", ft1, 2'b11);
    chk("abort_id", id1, 29'd0);
    chk("abort_data_len", len1, 7'd0);
    send_frame(1, 0, 29'h3C3, 0, 0, 0, 0, 0, 4'h8, -1, 0, 1);

    // abort and sof together: stays idle
    sp(1, 1'b0, 1'b1, 1'b1);
    chk("abort_sof_busy", busy1, 1'b0);
    send_frame(1, 0, 29'h001, 0, 1, 0, 1, 1, 4'hE, -1, 0, 1);

    // partial frame then SOF restart
    send_frame(1, 1, 29'h1555AAAA, 0, 0, 0, 0, 0, 4'h1, 8, 0, 0);
    chk("partial_busy", busy1, 1'b1);
    send_frame(1, 0, 29'h64A, 0, 0, 0, 0, 0, 4'h4, -1, 0, 1);

    // asynchronous reset mid-frame
    send_frame(1, 1, 29'h0AAAAAAA, 0, 0, 0, 0, 0, 4'h1, 15, 0, 0);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_busy", busy1, 1'b0);
    chk("async_rst_id", id1, 29'd0);
    chk("async_rst_frame_type", ft1, 2'b11);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

`ifdef CAN_FMT_PROTOCOL_EXC_EN
    exc_cnt = 0;
    send_frame(1, 0, 29'h321, 0, 1, 1, 1, 0, 4'h6, -1, 0, 0);
    repeat (3) @(negedge clk);
    chk("proto_exc_pulses", exc_cnt, 1);
    chk("proto_exc_busy", busy1, 1'b0);
    chk("proto_exc_frame_type", ft1, 2'b11);
`endif

    for (int i = 0; i < 200; i++) begin
      if (q1.size() == 0 && q0.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_fd_queue", q1.size(), 0);
    chk("drain_cl_queue", q0.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/can_frame_format_decoder.md
Name: can_frame_format_decoder

Overview:
- Parametrised successor to the CAN frame-type classifier.
- Walks the destuffed arbitration and control fields bit-by-bit on sample-point strobes.
- Classifies each frame as classic data, classic remote or FD data. Extracts identifier, IDE, BRS, ESI and DLC, and decodes DLC to payload byte length.
- Sits between the bit-destuffer and the data-field / CRC sequencer, which consumes data_len and fmt_valid.

Parameters:
- FD_ENABLE, 1, 1 = recognise FDF bit and FD control fields; 0 = classic-only, FDF position treated as reserved r0/r1.
- LEN_W, 7, width of data_len output (must be >= 7).

Ports:
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- sp_valid  in  1  one-clk strobe; rx_bit valid this cycle (destuffed sample point)
- rx_bit  in  1  destuffed bus bit, 0 = dominant
- sof  in  1  qualifies the current sp_valid as the SOF bit
- abort  in  1  error/bus-off/arbitration-loss; cancels decode
- busy  out  1  decode in progress
- fmt_valid  out  1  one-clk pulse, format fields valid
- frame_type  out  2  00 classic data, 01 classic remote, 10 FD data, 11 none
- ide  out  1  extended identifier
- id  out  29  identifier; base ID in [10:0], upper bits 0 when ide=0
- brs  out  1  bit-rate switch (FD only, else 0)
- esi  out  1  error-state indicator (FD only, else 0)
- dlc  out  4  raw DLC
- data_len  out  LEN_W  payload bytes

Behaviour:
- Reset values: busy=0, fmt_valid=0, frame_type=2'b11, ide=0, id=0, brs=0, esi=0, dlc=0, data_len=0.
- State advances only on clk edges where sp_valid=1; rx_bit is ignored otherwise.
- State machine: IDLE -> BASE_ID(11) -> B12 -> IDE -> {EXT_ID(18) -> RTR_X} -> FDF -> {R0 | RES -> BRS -> ESI} -> DLC(4) -> IDLE.
- A 5-bit counter sequences BASE_ID, EXT_ID and DLC, MSB first.
- IDLE: sp_valid & sof -> BASE_ID with count cleared. busy=1 in every state except IDLE.
- B12 holds RTR (base) or SRR (ext). IDE=1 -> EXT_ID; IDE=0 -> FDF, and the RTR candidate is B12.
- RTR_X holds RTR/RRS for extended frames.
- FDF: if FD_ENABLE and bit=1 -> RES (FD path); else classic.
  - Classic base: FDF position is r0 -> DLC.
  - Classic ext: FDF position is r1 -> R0 -> DLC.
- Classification:
  - FD -> 10; RTR/RRS ignored.
  - Classic with RTR=1 -> 01.
  - Otherwise -> 00.
- Length:
  - Classic data: min(dlc, 8).
  - Remote: 0, raw dlc still reported.
  - FD: 0..8 direct; 9,10,11,12,13,14,15 -> 12,16,20,24,32,48,64.
- Completion: on the edge sampling the last DLC bit, all outputs are registered and fmt_valid=1 for exactly one cycle, then IDLE.
  - Latency: fmt_valid is high in the clk cycle following the final DLC sample.
- Outputs hold until the next completed frame or an abort.
- abort=1 (any state): next edge -> IDLE, busy=0, no fmt_valid. frame_type, id, ide, brs, esi, dlc and data_len clear to their reset values.
- Simultaneous events:
  - abort and sof in the same cycle: abort wins; stay IDLE.
  - sof while busy: restart at BASE_ID and discard the partial frame.
- Reset mid-frame: immediate return to reset values, independent of clk.

Optional Feature:
- Macro CAN_FMT_PROTOCOL_EXC_EN.
- Defined: adds output proto_exc (1 bit, reset 0). In state RES with rx_bit=1, proto_exc pulses one cycle, decode aborts to IDLE with abort semantics, and fmt_valid is not asserted.
- Undefined: port absent; the RES bit value is ignored.

Decomposition:
- Package can_fmt_pkg: frame_type_t enum (FT_CLASSIC_DATA, FT_CLASSIC_REMOTE, FT_FD_DATA, FT_NONE), fmt_state_t enum, field-length constants (BASE_ID_LEN=11, EXT_ID_LEN=18, DLC_LEN=4).
- Sub-module can_dlc_len: combinational DLC + type -> data_len lookup, reused by the TX path.

Test Plan:
- Classic base data, ID 0x123, RTR=0, IDE=0, r0=0, DLC=0xA -> fmt_valid once, frame_type=00, id=0x123, ide=0, data_len=8, dlc=0xA.
- Classic base remote, ID 0x7FF, RTR=1, DLC=3 -> frame_type=01, data_len=0, dlc=3.
- FD extended, ID 0x12345678 (29-bit), FDF=1, res=0, BRS=1, ESI=0, DLC=0xD -> frame_type=10, ide=1, brs=1, data_len=32.
- FD_ENABLE=0, base frame with FDF position=1, DLC=5 -> frame_type=00, brs=0, data_len=5.
- abort asserted on the 10th EXT_ID bit -> busy=0 next cycle, no fmt_valid, frame_type=11. A following clean frame decodes correctly.
- CAN_FMT_PROTOCOL_EXC_EN defined, FD base frame with res=1 -> proto_exc single pulse, no fmt_valid, busy=0.
